// File: rtl/rca_32.sv
// Registered ripple-carry adder: {Cout,Sum} = A + B + Cin, one cycle of latency.
// The sum comes from an explicit chain of 1-bit full-adder cells.
// The carry ripples strictly from the LSB to the MSB, with no lookahead or select logic.

// One full-adder cell. The carry-out uses the generate/propagate form.
module rca_32_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

module rca_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  // carry[i] is the carry into bit i. carry[WIDTH] is the unsigned overflow.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    rca_32_fa_cell u_cell (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i]),
      .s  (sum_comb[i]),
      .co (carry[i+1])
    );
  end

  // Output register: clears at once on reset, and otherwise captures the chain result on every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum  <= '0;
      Cout <= 1'b0;
    end else begin
      Sum  <= sum_comb;
      Cout <= carry[WIDTH];
    end
  end

endmodule

// File: tb/tb_rca_32.sv
// Self-checking bench for rca_32. It drives WIDTH=32, 8 and 1 instances with shared stimulus.
// Expected results come from plain wide-integer addition.
module tb_rca_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;

  logic [31:0] sum32;
  logic        cout32;
  logic [7:0]  sum8;
  logic        cout8;
  logic [0:0]  sum1;
  logic        cout1;

  logic [32:0] exp32 = '0;
  logic [32:0] exp8 = '0;
  logic [32:0] exp1 = '0;
  logic [32:0] hold32, hold8, hold1;

  int total = 0;
  int bad = 0;

  rca_32 #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .Cin(cin), .Sum(sum32), .Cout(cout32)
  );

  rca_32 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .A(a[7:0]), .B(b[7:0]), .Cin(cin), .Sum(sum8), .Cout(cout8)
  );

  rca_32 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .A(a[0:0]), .B(b[0:0]), .Cin(cin), .Sum(sum1), .Cout(cout1)
  );

  always #5 clk = ~clk;

  // Reference model: masked operands are added as 64-bit integers.
  // The low w+1 bits hold {Cout,Sum}.
  function automatic logic [32:0] ref_add(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input logic c);
    longint unsigned m;
    longint unsigned s;
    m = (64'd1 << w) - 64'd1;
    s = ({32'd0, x} & m) + ({32'd0, y} & m) + {63'd0, c};
    return s[32:0];
  endfunction

  task automatic apply(input logic [31:0] x, input logic [31:0] y, input logic c);
    a = x;
    b = y;
    cin = c;
    exp32 = ref_add(32, x, y, c);
    exp8  = ref_add(8, x, y, c);
    exp1  = ref_add(1, x, y, c);
  endtask

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input logic [32:0] e32,
                           input logic [32:0] e8, input logic [32:0] e1);
    check({tag, "_w32"}, {cout32, sum32}, e32);
    check({tag, "_w8"},  {24'd0, cout8, sum8}, e8);
    check({tag, "_w1"},  {31'd0, cout1, sum1}, e1);
  endtask

  initial begin
    // Reset is held from time zero. The outputs must read zero before any edge and while inputs toggle.
    #1;
    check_all("reset_t0", '0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      apply($urandom, $urandom, 1'($urandom_range(0, 1)));
      @(posedge clk);
      #1;
      check_all("reset_held", '0, '0, '0);
    end

    // Release reset mid-cycle. The first capture happens on the following edge.
    #2;
    rst_n = 1'b1;
    apply(32'd2134352, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    check_all("basic1", exp32, exp8, exp1);
    check("basic1_const", {cout32, sum32}, 33'd2134352);

    apply(32'd2134352, 32'd1245465, 1'b0);
    @(posedge clk);
    #1;
    check_all("basic2", exp32, exp8, exp1);
    check("basic2_const", {cout32, sum32}, 33'd3379817);

    apply(32'd2134352, 32'd1245465, 1'b1);
    @(posedge clk);
    #1;
    check_all("basic3", exp32, exp8, exp1);
    check("basic3_const", {cout32, sum32}, 33'd3379818);

    // Full-length ripple cases.
    apply(32'hFFFF_FFFF, 32'd0, 1'b1);
    @(posedge clk);
    #1;
    check_all("ripple", exp32, exp8, exp1);
    check("ripple_const", {cout32, sum32}, {1'b1, 32'h0000_0000});
    check("ripple_const_w8", {24'd0, cout8, sum8}, 33'h100);
    check("ripple_const_w1", {31'd0, cout1, sum1}, 33'h2);

    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    @(posedge clk);
    #1;
    check_all("maxmax", exp32, exp8, exp1);
    check("maxmax_const", {cout32, sum32}, {1'b1, 32'hFFFF_FFFF});
    check("maxmax_const_w8", {24'd0, cout8, sum8}, 33'h1FF);
    check("maxmax_const_w1", {31'd0, cout1, sum1}, 33'h3);

    // Inputs that change between edges must not disturb the registered outputs.
    hold32 = exp32;
    hold8  = exp8;
    hold1  = exp1;
    #2;
    apply(32'h1234_5678, 32'h8765_4321, 1'b0);
    #2;
    check_all("hold", hold32, hold8, hold1);
    @(posedge clk);
    #1;
    check_all("after_hold", exp32, exp8, exp1);

    // Asynchronous reset between edges clears the outputs with no clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", '0, '0, '0);
    apply(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
    @(posedge clk);
    #1;
    check_all("async_reset_held", '0, '0, '0);
    #2;
    rst_n = 1'b1;
    #1;
    check_all("after_release", '0, '0, '0);
    @(posedge clk);
    #1;
    check_all("post_release", exp32, exp8, exp1);

    // Randomized back-to-back operations, one per cycle.
    for (int i = 0; i < 10000; i++) begin
      apply($urandom, $urandom, 1'($urandom_range(0, 1)));
      @(posedge clk);
      #1;
      check_all("random", exp32, exp8, exp1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
